// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op-code constants,
// op-code width and a constant clog2 used to size the pipeline.
package shift_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One barrel-shifter stage: shifts/rotates by DIST = 2^K when amount bit K
// is set, then registers the result with its sideband fields.
// Optional carry tracking is built only with SHIFT_PIPE_FLAGS_EN defined.
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int AMT_W = 3,
  parameter int K     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_sign,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef SHIFT_PIPE_FLAGS_EN
  input  logic              in_carry,
`endif
  input  logic              next_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [AMT_W-1:0]  out_amt,
  output logic [OP_W-1:0]   out_op,
  output logic              out_sign,
  output logic [TAG_W-1:0]  out_tag
`ifdef SHIFT_PIPE_FLAGS_EN
  ,
  output logic              out_carry
`endif
);

  localparam int DIST = 1 << K;

  logic [WIDTH-1:0] shifted;
  logic             ready;

  // This stage can take a new value when it is empty or its content moves on.
  assign ready = !out_valid || next_ready;

  // Shift/rotate mux by this stage's fixed distance; SRA fills with the
  // sign bit captured at pipe entry, not the current MSB.
  always_comb begin
    shifted = in_data;
    if (in_amt[K]) begin
      case (in_op)
        OP_SLL:  shifted = in_data << DIST;
        OP_SRL:  shifted = in_data >> DIST;
        OP_SRA:  shifted = {{DIST{in_sign}}, in_data[WIDTH-1:DIST]};
        OP_ROL:  shifted = {in_data[WIDTH-1-DIST:0], in_data[WIDTH-1:WIDTH-DIST]};
        OP_ROR:  shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
        default: shifted = in_data;
      endcase
    end
  end

`ifdef SHIFT_PIPE_FLAGS_EN
  logic carry_next;

  // Last bit shifted out: a shifting stage overwrites it, otherwise forward.
  always_comb begin
    carry_next = in_carry;
    if (in_amt[K]) begin
      case (in_op)
        OP_SLL, OP_ROL:         carry_next = in_data[WIDTH-DIST];
        OP_SRL, OP_SRA, OP_ROR: carry_next = in_data[DIST-1];
        default:                carry_next = in_carry;
      endcase
    end
  end
`endif

  // Stage register: flush drops the valid bit, a stall holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_op    <= '0;
      out_sign  <= 1'b0;
      out_tag   <= '0;
`ifdef SHIFT_PIPE_FLAGS_EN
      out_carry <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ready) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_amt   <= in_amt;
      out_op    <= in_op;
      out_sign  <= in_sign;
      out_tag   <= in_tag;
`ifdef SHIFT_PIPE_FLAGS_EN
      out_carry <= carry_next;
`endif
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR, other op codes pass the
// operand through) with one register stage per shift-amount bit.
// Define SHIFT_PIPE_FLAGS_EN to add the out_carry/out_zero flag outputs.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A stage is ready when it is empty or the stage after it is ready; the last
// stage's successor is out_ready, and in_ready is stage 0's ready. flush
// wins over both handshakes and empties every stage on the next edge.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_res,
  output logic [TAG_W-1:0]  out_tag
`ifdef SHIFT_PIPE_FLAGS_EN
  ,
  output logic              out_carry,
  output logic              out_zero
`endif
);

  localparam int STAGES = clog2(WIDTH);

  // Index k is the input of stage k; index k+1 is its registered output.
  logic [STAGES:0]     vld;
  logic [STAGES:0]     rdy;
  logic [WIDTH-1:0]    dat [STAGES+1];
  logic [STAGES-1:0]   amt [STAGES+1];
  logic [OP_W-1:0]     op  [STAGES+1];
  logic [STAGES:0]     sgn;
  logic [TAG_W-1:0]    tag [STAGES+1];
`ifdef SHIFT_PIPE_FLAGS_EN
  logic [STAGES:0]     cry;
`endif

  assign vld[0] = in_valid;
  assign dat[0] = in_a;
  assign amt[0] = in_b[STAGES-1:0];
  assign op[0]  = in_op;
  assign sgn[0] = in_a[WIDTH-1];
  assign tag[0] = in_tag;
`ifdef SHIFT_PIPE_FLAGS_EN
  assign cry[0] = 1'b0;
`endif

  // Ready chain derived from the registered valids, walked from the output back.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !vld[k+1] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_pipe_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .AMT_W (STAGES),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (vld[k]),
      .in_data    (dat[k]),
      .in_amt     (amt[k]),
      .in_op      (op[k]),
      .in_sign    (sgn[k]),
      .in_tag     (tag[k]),
`ifdef SHIFT_PIPE_FLAGS_EN
      .in_carry   (cry[k]),
`endif
      .next_ready (rdy[k+1]),
      .out_valid  (vld[k+1]),
      .out_data   (dat[k+1]),
      .out_amt    (amt[k+1]),
      .out_op     (op[k+1]),
      .out_sign   (sgn[k+1]),
      .out_tag    (tag[k+1])
`ifdef SHIFT_PIPE_FLAGS_EN
      ,
      .out_carry  (cry[k+1])
`endif
    );
  end

  assign out_valid = vld[STAGES];
  assign out_res   = dat[STAGES];
  assign out_tag   = tag[STAGES];

`ifdef SHIFT_PIPE_FLAGS_EN
  assign out_carry = cry[STAGES];
  // Qualified by valid so the flag reads 0 out of reset and when empty.
  assign out_zero  = vld[STAGES] && (dat[STAGES] == '0);
`endif

  // Fields that leave the last stage, and the ignored upper amount bits.
  logic unused_tail;
  assign unused_tail = ^{amt[STAGES], op[STAGES], sgn[STAGES], in_b};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=8, three stages). Works with or
// without SHIFT_PIPE_FLAGS_EN.
module tb_shift_pipe;
  import shift_pkg::*;

  localparam int WIDTH  = 8;
  localparam int TAG_W  = 4;
  localparam int STAGES = 3;
  localparam int EW     = 1 + WIDTH + TAG_W;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
`ifdef SHIFT_PIPE_FLAGS_EN
  logic             out_carry;
  logic             out_zero;
`endif

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
`ifdef SHIFT_PIPE_FLAGS_EN
    ,
    .out_carry (out_carry),
    .out_zero  (out_zero)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word shift/rotate by the amount in the low bits of b.
  function automatic logic [WIDTH-1:0] model_res(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    int amt;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0] r;
    amt = int'(b) % WIDTH;
    dbl = {a, a};
    case (op)
      OP_SLL:  r = a << amt;
      OP_SRL:  r = a >> amt;
      OP_SRA:  r = $signed(a) >>> amt;
      OP_ROL:  begin dbl = dbl << amt; r = dbl[2*WIDTH-1:WIDTH]; end
      OP_ROR:  begin dbl = dbl >> amt; r = dbl[WIDTH-1:0]; end
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic model_carry(input logic [2:0] op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    int amt;
    logic [WIDTH-1:0] r;
    amt = int'(b) % WIDTH;
    r = model_res(op, a, b);
    if (amt == 0) return 1'b0;
    case (op)
      OP_SLL:         return a[WIDTH-amt];
      OP_SRL, OP_SRA: return a[amt-1];
      OP_ROL:         return r[0];
      OP_ROR:         return r[WIDTH-1];
      default:        return 1'b0;
    endcase
  endfunction

  // Compare process: every output-valid cycle against the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] head;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mon_unexpected: got out_valid=1 tag 0x%0h, expected no result at %0t", out_tag, $time);
        end else begin
          head = exp_q[0];
          check("mon_res", 32'(out_res), 32'(head[TAG_W+WIDTH-1:TAG_W]));
          check("mon_tag", 32'(out_tag), 32'(head[TAG_W-1:0]));
`ifdef SHIFT_PIPE_FLAGS_EN
          check("mon_carry", 32'(out_carry), 32'(head[EW-1]));
          check("mon_zero", 32'(out_zero), 32'(head[TAG_W+WIDTH-1:TAG_W] == '0));
`endif
          if (out_ready && !flush) void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back({model_carry(in_op, in_a, in_b), model_res(in_op, in_a, in_b), in_tag});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag);
    in_op  = op;
    in_a   = a;
    in_b   = b;
    in_tag = tag;
  endtask

  // Present one request and hold it until accepted; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag);
    bit acc;
    int c;
    acc = 0;
    c = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    set_req(op, a, b, tag);
    while (!acc && c < 20) begin
      @(negedge clk);
      acc = in_ready && !flush;
      c++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("issue_accepted", 32'(acc), 1);
  endtask

  // Wait for the next result, check latency and contents against literals.
  task automatic wait_result(input logic [7:0] er, input logic [3:0] et, input logic ec);
    bit got;
    int c;
    got = 0;
    c = 0;
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      if (out_valid) got = 1;
    end
    check("result_arrived", 32'(got), 1);
    if (got) begin
      check("latency", 32'(c), STAGES);
      check("res", 32'(out_res), 32'(er));
      check("tag", 32'(out_tag), 32'(et));
`ifdef SHIFT_PIPE_FLAGS_EN
      check("carry", 32'(out_carry), 32'(ec));
      check("zero", 32'(out_zero), 32'(er == 8'h00));
`else
      if (ec === 1'bx) $display("carry expectation unknown");
`endif
    end
  endtask

  // ---------------- directed vectors ----------------
  logic [2:0] s_op  [8] = '{OP_SLL, OP_SRA, OP_SRL, OP_ROR, OP_SLL, 3'b110, OP_SLL, OP_SRA};
  logic [7:0] s_a   [8] = '{8'h81, 8'h90, 8'hF0, 8'h01, 8'hA5, 8'h3C, 8'h80, 8'h80};
  logic [7:0] s_b   [8] = '{8'h03, 8'h02, 8'h0C, 8'h01, 8'h00, 8'h07, 8'h01, 8'h07};
  logic [7:0] s_res [8] = '{8'h08, 8'hE4, 8'h0F, 8'h80, 8'hA5, 8'h3C, 8'h00, 8'hFF};
  logic       s_cry [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] rol_tbl [8] = '{8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B};

  initial begin
    int idx;
    int nt;
    bit acc;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_req(3'b000, 8'h00, 8'h00, 4'h0);

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_res", 32'(out_res), 0);
    check("rst_out_tag", 32'(out_tag), 0);
`ifdef SHIFT_PIPE_FLAGS_EN
    check("rst_out_carry", 32'(out_carry), 0);
    check("rst_out_zero", 32'(out_zero), 0);
`endif
    #9;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Single operations, including amount 0, pass-through op and a zero result
    for (int i = 0; i < 8; i++) begin
      issue(s_op[i], s_a[i], s_b[i], 4'(i + 1));
      wait_result(s_res[i], 4'(i + 1), s_cry[i]);
    end

    // Back-to-back ROL stream, one result per cycle
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1;
          set_req(OP_ROL, 8'h96, 8'(i), 4'(i));
          @(negedge clk);
          check("stream_in_ready", 32'(in_ready), 1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int c;
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 20) begin
          @(negedge clk);
          c++;
        end
        for (int i = 0; i < 8; i++) begin
          check("stream_valid", 32'(out_valid), 1);
          check("stream_res", 32'(out_res), 32'(rol_tbl[i]));
          check("stream_tag", 32'(out_tag), 32'(i));
          if (i < 7) @(negedge clk);
        end
      end
    join

    // Backpressure: 6 stalled cycles, 5 offered requests
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    set_req(OP_ROL, 8'hC3, 8'(idx), 4'(idx));
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc >= 3) begin
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_head_res", 32'(out_res), 'hC3);
        check("bp_head_tag", 32'(out_tag), 0);
      end
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        set_req(OP_ROL, 8'hC3, 8'(idx), 4'(idx));
      end
    end
    check("bp_accepts", 32'(idx), 3);
    check("bp_in_ready_low", 32'(in_ready), 0);
    out_ready = 1'b1;
    nt = 0;
    for (int c = 0; c < 30 && nt < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("bp_order_tag", 32'(out_tag), 32'(nt));
        nt++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx == 5) in_valid = 1'b0;
        else set_req(OP_ROL, 8'hC3, 8'(idx), 4'(idx));
      end
    end
    check("bp_count", 32'(nt), 5);
    repeat (3) @(negedge clk);

    // Flush with three in flight and a fourth offered
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_req(OP_SLL, 8'(i + 1), 8'h01, 4'(8 + i));
      @(negedge clk);
      check("fl_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    set_req(OP_SLL, 8'h55, 8'h01, 4'd11);
    flush = 1'b1;
    @(negedge clk);
    check("fl_out_valid_before", 32'(out_valid), 1);
    check("fl_offered_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fl_out_valid", 32'(out_valid), 0);
    end
    issue(OP_SRL, 8'h80, 8'h07, 4'd12);
    wait_result(8'h01, 4'd12, 1'b0);

    // Asynchronous reset in the middle of a stream
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_req(OP_SRL, 8'hF0, 8'(i), 4'(i));
      @(posedge clk); #1;
    end
    check("rst_mid_pre_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_async_valid", 32'(out_valid), 0);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 1);
    check("rst_mid_out_res", 32'(out_res), 0);
    issue(OP_SLL, 8'h01, 8'h07, 4'd13);
    wait_result(8'h80, 4'd13, 1'b0);

    // Drain and confirm nothing was lost
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
